// File: rtl/serial_prog_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_prog_pkg : shared constants, FSM encoding and display colours |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_prog_pkg;

    localparam int          WORD_W      = 16;
    localparam logic [15:0] HS_BLANK_LO = 16'h0000;
    localparam logic [15:0] HS_BLANK_HI = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HS_I  = 3'd1,
        ST_DATA  = 3'd2,
        ST_HS_F  = 3'd3,
        ST_FLUSH = 3'd4
    } rx_state_t;

    // Colour codes shared with the handshake display monitor
    localparam logic [1:0] RED       = 2'b00;
    localparam logic [1:0] LIGHTBLUE = 2'b10;
    localparam logic [1:0] BLUE      = 2'b11;

    // A blank line (all zeros or all ones) never counts as a valid handshake
    function automatic logic hs_match(input logic [15:0] hs_start, input logic [15:0] hs_end);
        return (hs_start == hs_end) && (hs_end != HS_BLANK_LO) && (hs_end != HS_BLANK_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_prog_rx_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser with asynchronous reset value       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_prog_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_prog_rx : serial programming link receiver (hs / payload / hs) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_prog_rx #(
    parameter int N_WORDS = 8,
    parameter int WORD_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      sdi,
    input  logic                      cs_n,
    output logic [WORD_W-1:0]         hs_i,
    output logic [WORD_W-1:0]         hs_f,
    output logic [WORD_W*N_WORDS-1:0] data_out,
    output logic                      frame_done,
    output logic                      data_upd,
    output logic                      frame_err
);

    import serial_prog_pkg::*;

    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BIT_W = $clog2(WORD_W);

    logic [1:0]                sync_dat;
    logic                      s_sclk, s_sdi, s_cs_n;
    logic                      s_sclk_d, s_cs_n_d;
    logic [1:0]                warm;
    logic                      hi_seen;
    rx_state_t                 state, next_state;
    logic [WORD_W-1:0]         shift_reg;
    logic [BIT_W-1:0]          bit_cnt;
    logic [CNT_W-1:0]          word_cnt;
    logic [WORD_W*N_WORDS-1:0] shadow;
    logic [WORD_W-1:0]         hs_i_shadow;
    logic                      commit;

    logic                      rise, cs_fall, cs_rise, in_frame, abort, capture, word_done, last_word;
    logic [WORD_W-1:0]         word;

    sync_2ff #(.WIDTH(2), .RST_VAL(2'b00)) u_sync_dat (
        .clk (clk),
        .rst (rst),
        .d   ({sclk, sdi}),
        .q   (sync_dat)
    );

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (s_cs_n)
    );

    assign s_sclk = sync_dat[1];
    assign s_sdi  = sync_dat[0];

    // The synchroniser's reset value of 1 is not a real observation of cs_n high,
    // so a frame may only start once cs_n has been seen high after the flops flush.
    assign rise      = s_sclk & ~s_sclk_d;
    assign cs_fall   = hi_seen & s_cs_n_d & ~s_cs_n;
    assign cs_rise   = ~s_cs_n_d & s_cs_n;
    assign in_frame  = (state == ST_HS_I) || (state == ST_DATA) || (state == ST_HS_F);
    assign abort     = in_frame & cs_rise;
    assign capture   = in_frame & rise & ~s_cs_n;
    assign word      = {shift_reg[WORD_W-2:0], s_sdi};
    assign word_done = capture & (bit_cnt == '1);
    assign last_word = (word_cnt == CNT_W'(N_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cs_fall) next_state = ST_HS_I;
            end
            ST_HS_I: begin
                if (abort)          next_state = ST_IDLE;
                else if (word_done) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (abort)                       next_state = ST_IDLE;
                else if (word_done && last_word) next_state = ST_HS_F;
            end
            ST_HS_F: begin
                if (abort)          next_state = ST_IDLE;
                else if (word_done) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (s_cs_n) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_sclk_d    <= 1'b0;
            s_cs_n_d    <= 1'b1;
            warm        <= 2'b00;
            hi_seen     <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            shadow      <= '0;
            hs_i_shadow <= '0;
            commit      <= 1'b0;
            hs_i        <= '0;
            hs_f        <= '0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            data_upd    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            s_sclk_d   <= s_sclk;
            s_cs_n_d   <= s_cs_n;
            warm       <= {warm[0], 1'b1};
            hi_seen    <= hi_seen | (warm[1] & s_cs_n);
            frame_done <= 1'b0;
            data_upd   <= 1'b0;
            frame_err  <= 1'b0;
            commit     <= 1'b0;

            if (abort) begin
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end else if (capture) begin
                shift_reg <= word;
                bit_cnt   <= bit_cnt + 1'b1;
            end

            if (word_done) begin
                case (state)
                    ST_HS_I: begin
                        hs_i_shadow <= word;
                        word_cnt    <= '0;
                    end
                    ST_DATA: begin
                        shadow[word_cnt*WORD_W +: WORD_W] <= word;
                        word_cnt                          <= word_cnt + 1'b1;
                    end
                    ST_HS_F: commit <= 1'b1;
                    default: ;
                endcase
            end

            // shift_reg is frozen in FLUSH, so it still holds the end handshake here
            if (commit) begin
                hs_i       <= hs_i_shadow;
                hs_f       <= shift_reg;
                frame_done <= 1'b1;
                if (hs_match(hs_i_shadow, shift_reg)) begin
                    data_out <= shadow;
                    data_upd <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_prog_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_prog_rx : randomized self-checking bench for serial_prog_rx |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_serial_prog_rx;

    localparam int NW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            sclk;
    logic            sdi;
    logic            cs_n;
    logic [15:0]     hs_i;
    logic [15:0]     hs_f;
    logic [16*NW-1:0] data_out;
    logic            frame_done;
    logic            data_upd;
    logic            frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    logic [15:0] tx_pay  [NW];
    logic [15:0] exp_data[NW];
    logic [15:0] exp_hs_i;
    logic [15:0] exp_hs_f;

    serial_prog_rx #(.N_WORDS(NW), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .sdi        (sdi),
        .cs_n       (cs_n),
        .hs_i       (hs_i),
        .hs_f       (hs_f),
        .data_out   (data_out),
        .frame_done (frame_done),
        .data_upd   (data_upd),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (data_upd)   upd_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a frame is published only if both handshakes agree and are not blank
    task automatic model_frame(input logic [15:0] s, input logic [15:0] e, output bit upd);
        exp_hs_i = s;
        exp_hs_f = e;
        upd = (s == e) && (e != 16'h0000) && (e != 16'hFFFF);
        if (upd) for (int k = 0; k < NW; k++) exp_data[k] = tx_pay[k];
    endtask

    function automatic logic [16*NW-1:0] exp_packed();
        logic [16*NW-1:0] v;
        for (int k = 0; k < NW; k++) v[16*k +: 16] = exp_data[k];
        return v;
    endfunction

    // Leaves sclk high with the rising edge 3 time units after a clk posedge
    task automatic send_bit(input logic b);
        @(posedge clk); #3 sclk = 1'b0; sdi = b;
        repeat (3) @(posedge clk);
        #3 sclk = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic begin_frame();
        @(posedge clk); #3 cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] s, input logic [15:0] e);
        begin_frame();
        send_word(s);
        for (int k = 0; k < NW; k++) send_word(tx_pay[k]);
        send_word(e);
    endtask

    task automatic end_frame();
        @(posedge clk); #3 sclk = 1'b0;
        repeat (6) @(posedge clk);
        #3 cs_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; sdi = 1'b0; cs_n = 1'b1;
        exp_hs_i = '0; exp_hs_f = '0;
        for (int k = 0; k < NW; k++) exp_data[k] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (hs_i !== 16'h0000) begin n_bad++; $display("FAIL reset_hs_i: got %h want 0000", hs_i); end
        n_cmp++; if (hs_f !== 16'h0000) begin n_bad++; $display("FAIL reset_hs_f: got %h want 0000", hs_f); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_cmp++; if ((done_cnt + upd_cnt + err_cnt) !== 0) begin
            n_bad++; $display("FAIL reset_pulses: got %0d/%0d/%0d want 0/0/0", done_cnt, upd_cnt, err_cnt);
        end
    endtask

    task automatic test_good_frame();
        int  d0, u0;
        bit  upd;
        logic [15:0] keep_hs;
        logic [16*NW-1:0] keep_data;
        for (int k = 0; k < NW; k++) tx_pay[k] = 16'(k + 1);
        d0 = done_cnt; u0 = upd_cnt;
        send_frame(16'hA5C3, 16'hA5C3);
        model_frame(16'hA5C3, 16'hA5C3, upd);
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL good_early: frame_done got %b want 0 at clk 3", frame_done); end
        @(posedge clk); #1;
        n_cmp++; if ({frame_done, data_upd} !== 2'b11) begin
            n_bad++; $display("FAIL good_latency: done/upd got %b%b want 11 at clk 4", frame_done, data_upd);
        end
        n_cmp++; if (hs_i !== 16'hA5C3 || hs_f !== 16'hA5C3) begin
            n_bad++; $display("FAIL good_hs: got %h/%h want a5c3/a5c3", hs_i, hs_f);
        end
        n_cmp++; if (data_out[15:0] !== 16'h0001 || data_out[127:112] !== 16'h0008) begin
            n_bad++; $display("FAIL good_words: word0 %h word7 %h want 0001 0008", data_out[15:0], data_out[127:112]);
        end
        n_cmp++; if (data_out !== exp_packed()) begin n_bad++; $display("FAIL good_data: got %h want %h", data_out, exp_packed()); end
        @(posedge clk); #1;
        n_cmp++; if ({frame_done, data_upd} !== 2'b00) begin
            n_bad++; $display("FAIL good_pulse_width: done/upd got %b%b want 00", frame_done, data_upd);
        end
        // Extra sclk edges with cs_n still low must be ignored
        keep_hs = hs_f; keep_data = data_out;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (hs_f !== keep_hs || data_out !== keep_data) begin
            n_bad++; $display("FAIL flush_hold: hs_f %h data %h want %h %h", hs_f, data_out, keep_hs, keep_data);
        end
        n_cmp++; if (done_cnt - d0 !== 1 || upd_cnt - u0 !== 1) begin
            n_bad++; $display("FAIL good_count: done %0d upd %0d want 1 1", done_cnt - d0, upd_cnt - u0);
        end
        end_frame();
    endtask

    task automatic test_mismatch();
        int d0, u0;
        bit upd;
        for (int k = 0; k < NW; k++) tx_pay[k] = 16'hBEEF;
        d0 = done_cnt; u0 = upd_cnt;
        send_frame(16'h1234, 16'h1235);
        model_frame(16'h1234, 16'h1235, upd);
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (hs_i !== 16'h1234 || hs_f !== 16'h1235) begin
            n_bad++; $display("FAIL mismatch_hs: got %h/%h want 1234/1235", hs_i, hs_f);
        end
        n_cmp++; if (data_out !== exp_packed()) begin n_bad++; $display("FAIL mismatch_data: got %h want %h", data_out, exp_packed()); end
        n_cmp++; if (done_cnt - d0 !== 1 || upd_cnt - u0 !== 0) begin
            n_bad++; $display("FAIL mismatch_pulses: done %0d upd %0d want 1 0", done_cnt - d0, upd_cnt - u0);
        end
        end_frame();
    endtask

    task automatic test_blank();
        int d0, u0;
        bit upd;
        for (int k = 0; k < NW; k++) tx_pay[k] = 16'hFFFF;
        d0 = done_cnt; u0 = upd_cnt;
        send_frame(16'hFFFF, 16'hFFFF);
        model_frame(16'hFFFF, 16'hFFFF, upd);
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (hs_i !== 16'hFFFF || hs_f !== 16'hFFFF) begin
            n_bad++; $display("FAIL blank_hs: got %h/%h want ffff/ffff", hs_i, hs_f);
        end
        n_cmp++; if (data_out !== exp_packed()) begin n_bad++; $display("FAIL blank_data: got %h want %h", data_out, exp_packed()); end
        n_cmp++; if (done_cnt - d0 !== 1 || upd_cnt - u0 !== 0) begin
            n_bad++; $display("FAIL blank_pulses: done %0d upd %0d want 1 0", done_cnt - d0, upd_cnt - u0);
        end
        end_frame();
    endtask

    task automatic test_random();
        int d0, u0;
        bit upd;
        logic [15:0] s, e;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NW; k++) tx_pay[k] = 16'($urandom);
            s = 16'($urandom);
            case ($urandom_range(0, 3))
                0: e = s;
                1: e = s ^ (16'h1 << $urandom_range(0, 15));
                2: begin s = 16'h0000; e = 16'h0000; end
                default: e = s;
            endcase
            d0 = done_cnt; u0 = upd_cnt;
            send_frame(s, e);
            model_frame(s, e, upd);
            repeat (8) @(posedge clk); #1;
            n_cmp++; if (hs_i !== exp_hs_i || hs_f !== exp_hs_f) begin
                n_bad++; $display("FAIL rand%0d_hs: got %h/%h want %h/%h", it, hs_i, hs_f, exp_hs_i, exp_hs_f);
            end
            n_cmp++; if (data_out !== exp_packed()) begin
                n_bad++; $display("FAIL rand%0d_data: got %h want %h", it, data_out, exp_packed());
            end
            n_cmp++; if (done_cnt - d0 !== 1 || upd_cnt - u0 !== int'(upd)) begin
                n_bad++; $display("FAIL rand%0d_pulses: done %0d upd %0d want 1 %0d", it, done_cnt - d0, upd_cnt - u0, upd);
            end
            end_frame();
        end
    endtask

    task automatic test_abort();
        int d0, u0, e0;
        bit upd;
        d0 = done_cnt; u0 = upd_cnt; e0 = err_cnt;
        begin_frame();
        send_word(16'h1111);
        for (int k = 0; k < 3; k++) send_word(16'($urandom));
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (4) @(posedge clk);
        #3 cs_n = 1'b1; sclk = 1'b0;
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL abort_err: got %0d pulse clks want 1", err_cnt - e0); end
        n_cmp++; if (done_cnt - d0 !== 0 || upd_cnt - u0 !== 0) begin
            n_bad++; $display("FAIL abort_pulses: done %0d upd %0d want 0 0", done_cnt - d0, upd_cnt - u0);
        end
        n_cmp++; if (hs_i !== exp_hs_i || hs_f !== exp_hs_f || data_out !== exp_packed()) begin
            n_bad++; $display("FAIL abort_hold: hs %h/%h data %h want %h/%h %h", hs_i, hs_f, data_out, exp_hs_i, exp_hs_f, exp_packed());
        end
        for (int k = 0; k < NW; k++) tx_pay[k] = 16'($urandom) | 16'h0100;
        d0 = done_cnt; u0 = upd_cnt;
        send_frame(16'h5A5A, 16'h5A5A);
        model_frame(16'h5A5A, 16'h5A5A, upd);
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (hs_i !== 16'h5A5A || hs_f !== 16'h5A5A || data_out !== exp_packed()) begin
            n_bad++; $display("FAIL after_abort: hs %h/%h data %h want 5a5a/5a5a %h", hs_i, hs_f, data_out, exp_packed());
        end
        n_cmp++; if (done_cnt - d0 !== 1 || upd_cnt - u0 !== 1) begin
            n_bad++; $display("FAIL after_abort_pulses: done %0d upd %0d want 1 1", done_cnt - d0, upd_cnt - u0);
        end
        end_frame();
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit upd;
        begin_frame();
        send_word(16'h7777);
        for (int k = 0; k < 2; k++) send_word(16'($urandom));
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        @(posedge clk); #2 rst = 1'b1;
        #1;
        exp_hs_i = '0; exp_hs_f = '0;
        for (int k = 0; k < NW; k++) exp_data[k] = '0;
        n_cmp++; if (hs_i !== 16'h0 || hs_f !== 16'h0 || data_out !== '0) begin
            n_bad++; $display("FAIL reset_async: hs %h/%h data %h want 0000/0000 0", hs_i, hs_f, data_out);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        // cs_n stays low out of reset: nothing may be captured until it rises and falls again
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame();
        #1;
        n_cmp++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL held_low: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        n_cmp++; if (hs_i !== 16'h0 || data_out !== '0) begin
            n_bad++; $display("FAIL held_low_out: hs_i %h data %h want 0000 0", hs_i, data_out);
        end
        for (int k = 0; k < NW; k++) tx_pay[k] = 16'($urandom);
        send_frame(16'hC0DE, 16'hC0DE);
        model_frame(16'hC0DE, 16'hC0DE, upd);
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (hs_i !== 16'hC0DE || hs_f !== 16'hC0DE || data_out !== exp_packed()) begin
            n_bad++; $display("FAIL after_reset: hs %h/%h data %h want c0de/c0de %h", hs_i, hs_f, data_out, exp_packed());
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_mismatch();
        test_blank();
        test_random();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
